// File: rtl/rx_cic_pkg.sv
// Shared definitions for the CIC receive path.
// Holds the rate-controller state encoding and the legal decimation range,
// so that every block agrees on the same limits and reset rate.
package rx_cic_pkg;

    // Width of the decimation value driven to the CIC.
    localparam int unsigned RATE_WIDTH = 7;

    localparam int unsigned MIN_RATE     = 2;
    localparam int unsigned MAX_RATE     = 80;
    localparam int unsigned DEFAULT_RATE = 10;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StFill  = 2'd1,
        StRun   = 2'd2
    } state_e;

endpackage

// File: rtl/cic_fill_counter.sv
// Saturating counter of qualified CIC output strobes.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clr            : synchronous clear (takes priority over inc)
//   inc            : count one qualified strobe
//   count          : current count, saturates at MAX_COUNT
module cic_fill_counter #(
    parameter int unsigned MAX_COUNT = 5,
    parameter int unsigned WIDTH     = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != WIDTH'(MAX_COUNT))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// Decimation-rate controller for a CIC decimator.
// Accepts rate-change requests, clears the CIC when the rate changes, discards
// the first STAGES output samples after a clear (filter still filling) and then
// passes qualified output samples through with one clock of latency.
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   in_strobe                   : raw input-sample strobe
//   cfg_valid/cfg_rate/cfg_ready: rate-change request handshake
//   cfg_err                     : one-clock pulse for an out-of-range request
//   cic_rate, cic_clear         : decimation and synchronous clear to the CIC
//   cic_in_strobe               : gated input strobe to the CIC
//   cic_out_strobe/cic_out_data : raw CIC output
//   out_strobe/out_data         : qualified output sample
//   locked                      : high while running with valid output
module cic_rate_ctrl #(
    parameter int unsigned STAGES       = 5,
    parameter int unsigned OUT_WIDTH    = 18,
    parameter int unsigned MIN_RATE     = rx_cic_pkg::MIN_RATE,
    parameter int unsigned MAX_RATE     = rx_cic_pkg::MAX_RATE,
    parameter int unsigned DEFAULT_RATE = rx_cic_pkg::DEFAULT_RATE,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              in_strobe,
    input  logic                              cfg_valid,
    input  logic [rx_cic_pkg::RATE_WIDTH-1:0] cfg_rate,
    output logic                              cfg_ready,
    output logic                              cfg_err,
    output logic [rx_cic_pkg::RATE_WIDTH-1:0] cic_rate,
    output logic                              cic_clear,
    output logic                              cic_in_strobe,
    input  logic                              cic_out_strobe,
    input  logic [OUT_WIDTH-1:0]              cic_out_data,
    output logic                              out_strobe,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              locked
);

    import rx_cic_pkg::*;

    localparam int unsigned RW     = RATE_WIDTH;
    localparam int unsigned CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int unsigned FILL_W = $clog2(STAGES + 1);

    localparam logic [RW-1:0] MinR = RW'(MIN_RATE);
    localparam logic [RW-1:0] MaxR = RW'(MAX_RATE);
    localparam logic [RW-1:0] DefR = RW'(DEFAULT_RATE);

    state_e                 state_q, state_d;
    logic [CLR_W-1:0]       clear_cnt_q, clear_cnt_d;
    logic [RW-1:0]          rate_q, rate_d;
    logic                   err_q, err_d;
    logic                   out_strobe_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic [FILL_W-1:0]      fill_cnt;
    logic                   fill_inc;
    logic                   rate_legal;

    assign rate_legal = (cfg_rate >= MinR) && (cfg_rate <= MaxR);

    // Only strobes seen in FILL count; leaving FILL resets the count so the
    // next clear starts from zero.
    cic_fill_counter #(
        .MAX_COUNT (STAGES),
        .WIDTH     (FILL_W)
    ) u_fill_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state_q != StFill),
        .inc     (fill_inc),
        .count   (fill_cnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StClear;
            clear_cnt_q <= '0;
            rate_q      <= DefR;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            rate_q      <= rate_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clear_cnt_d   = clear_cnt_q;
        rate_d        = rate_q;
        err_d         = 1'b0;
        cic_clear     = 1'b0;
        cic_in_strobe = 1'b0;
        cfg_ready     = 1'b0;
        locked        = 1'b0;
        fill_inc      = 1'b0;
        unique case (state_q)
            StClear: begin
                cic_clear = 1'b1;
                if (clear_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d     = StFill;
                    clear_cnt_d = '0;
                end else begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                end
            end
            StFill: begin
                cic_in_strobe = in_strobe;
                fill_inc      = cic_out_strobe;
                if (cic_out_strobe && (fill_cnt == FILL_W'(STAGES - 1))) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cic_in_strobe = in_strobe;
                cfg_ready     = 1'b1;
                locked        = 1'b1;
                if (cfg_valid) begin
                    if (!rate_legal) begin
                        err_d = 1'b1;
                    end else if (cfg_rate != rate_q) begin
                        rate_d      = cfg_rate;
                        state_d     = StClear;
                        clear_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = StClear;
                clear_cnt_d = '0;
            end
        endcase
    end

    // Output is qualified by the current state, so a sample coincident with
    // a rate change is still emitted and nothing leaks out of CLEAR/FILL.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_strobe_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_strobe_q <= cic_out_strobe && locked;
            if (cic_out_strobe && locked) begin
                out_data_q <= cic_out_data;
            end
        end
    end

    assign cfg_err    = err_q;
    assign cic_rate   = rate_q;
    assign out_strobe = out_strobe_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed self-checking bench for cic_rate_ctrl.
module tb_cic_rate_ctrl;

    logic        clock;
    logic        reset_n;
    logic        in_strobe;
    logic        cfg_valid;
    logic [6:0]  cfg_rate;
    logic        cfg_ready;
    logic        cfg_err;
    logic [6:0]  cic_rate;
    logic        cic_clear;
    logic        cic_in_strobe;
    logic        cic_out_strobe;
    logic [17:0] cic_out_data;
    logic        out_strobe;
    logic [17:0] out_data;
    logic        locked;

    int checks   = 0;
    int failures = 0;

    cic_rate_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_strobe      (in_strobe),
        .cfg_valid      (cfg_valid),
        .cfg_rate       (cfg_rate),
        .cfg_ready      (cfg_ready),
        .cfg_err        (cfg_err),
        .cic_rate       (cic_rate),
        .cic_clear      (cic_clear),
        .cic_in_strobe  (cic_in_strobe),
        .cic_out_strobe (cic_out_strobe),
        .cic_out_data   (cic_out_data),
        .out_strobe     (out_strobe),
        .out_data       (out_data),
        .locked         (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply data-path inputs and let combinational outputs settle.
    task automatic drive(input logic istb, input logic ostb, input logic [17:0] odata);
        in_strobe      = istb;
        cic_out_strobe = ostb;
        cic_out_data   = odata;
        #1;
    endtask

    // One CIC output pulse followed by three idle clocks (input every 4 clocks).
    // Returns the qualified output seen one clock after the pulse.
    task automatic pulse(input logic [17:0] d, output logic ostb, output logic [17:0] odat);
        drive(1'b1, 1'b1, d);
        tick();
        ostb = out_strobe;
        odat = out_data;
        drive(1'b0, 1'b0, 18'h0);
        tick();
        tick();
        tick();
    endtask

    // Run the five discarded fill pulses; locked must rise only after the fifth.
    task automatic fill_seq(input string tag);
        logic        s;
        logic [17:0] d;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 18'h100 + 18'(i));
            chk({tag, "_fill_ready"}, cfg_ready, 1'b0);
            tick();
            chk({tag, "_fill_suppress"}, out_strobe, 1'b0);
            chk({tag, "_fill_locked"}, locked, (i == 4) ? 1'b1 : 1'b0);
            drive(1'b0, 1'b0, 18'h0);
            tick();
            tick();
            tick();
        end
        pulse(18'h2A5A5, s, d);
        chk({tag, "_first_out_stb"}, s, 1'b1);
        chk({tag, "_first_out_data"}, d, 18'h2A5A5);
        chk({tag, "_out_one_clk"}, out_strobe, 1'b0);
    endtask

    initial begin
        logic        s;
        logic [17:0] d;

        reset_n        = 1'b0;
        in_strobe      = 1'b0;
        cfg_valid      = 1'b0;
        cfg_rate       = 7'd0;
        cic_out_strobe = 1'b0;
        cic_out_data   = 18'h0;

        // Reset state.
        tick();
        drive(1'b1, 1'b1, 18'h3FFFF);
        chk("rst_clear", cic_clear, 1'b1);
        chk("rst_in_stb", cic_in_strobe, 1'b0);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_rate", cic_rate, 7'd10);
        chk("rst_err", cfg_err, 1'b0);
        tick();
        chk("rst_out_stb", out_strobe, 1'b0);
        chk("rst_out_data", out_data, 18'h0);

        // Release reset mid-cycle; CLEAR lasts two clocks and ignores strobes.
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 18'h12345);
        chk("clr0_clear", cic_clear, 1'b1);
        chk("clr0_in_drop", cic_in_strobe, 1'b0);
        tick();
        chk("clr1_clear", cic_clear, 1'b1);
        chk("clr1_out", out_strobe, 1'b0);
        drive(1'b0, 1'b0, 18'h0);
        tick();
        chk("fill_clear", cic_clear, 1'b0);
        drive(1'b1, 1'b0, 18'h0);
        chk("fill_in_pass", cic_in_strobe, 1'b1);
        drive(1'b0, 1'b0, 18'h0);
        tick();
        tick();
        fill_seq("init");

        // Illegal rates: rate 1 then 81.
        cfg_valid = 1'b1;
        cfg_rate  = 7'd1;
        #1;
        chk("lo_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk("lo_err", cfg_err, 1'b1);
        chk("lo_rate", cic_rate, 7'd10);
        chk("lo_locked", locked, 1'b1);
        tick();
        chk("lo_err_pulse", cfg_err, 1'b0);
        cfg_valid = 1'b1;
        cfg_rate  = 7'd81;
        tick();
        cfg_valid = 1'b0;
        chk("hi_err", cfg_err, 1'b1);
        chk("hi_rate", cic_rate, 7'd10);
        chk("hi_locked", locked, 1'b1);
        tick();
        chk("hi_err_pulse", cfg_err, 1'b0);

        // Same rate with a coincident output: acknowledged, no clear.
        cfg_valid = 1'b1;
        cfg_rate  = 7'd10;
        drive(1'b1, 1'b1, 18'h0BEEF);
        chk("same_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk("same_clear", cic_clear, 1'b0);
        chk("same_locked", locked, 1'b1);
        chk("same_out_stb", out_strobe, 1'b1);
        chk("same_out_data", out_data, 18'h0BEEF);
        drive(1'b0, 1'b0, 18'h0);
        tick();
        tick();
        tick();
        pulse(18'h1CAFE, s, d);
        chk("same_next_stb", s, 1'b1);
        chk("same_next_data", d, 18'h1CAFE);

        // Rate 20 with a coincident output sample: sample still emitted.
        cfg_valid = 1'b1;
        cfg_rate  = 7'd20;
        drive(1'b1, 1'b1, 18'h03C3C);
        tick();
        cfg_valid = 1'b0;
        chk("r20_rate", cic_rate, 7'd20);
        chk("r20_clear0", cic_clear, 1'b1);
        chk("r20_unlocked", locked, 1'b0);
        chk("r20_last_stb", out_strobe, 1'b1);
        chk("r20_last_data", out_data, 18'h03C3C);
        drive(1'b0, 1'b0, 18'h0);
        tick();
        chk("r20_clear1", cic_clear, 1'b1);
        tick();
        chk("r20_clear_end", cic_clear, 1'b0);
        fill_seq("r20");

        // Request 40 held through CLEAR/FILL: accepted only once locked.
        cfg_valid = 1'b1;
        cfg_rate  = 7'd40;
        tick();
        chk("r40_rate", cic_rate, 7'd40);
        chk("r40_clear", cic_clear, 1'b1);
        tick();
        tick();
        chk("hold_fill_ready", cfg_ready, 1'b0);
        tick();
        chk("hold_rate_keep", cic_rate, 7'd40);
        // Let four fill pulses pass with the request pending, at a new rate.
        cfg_rate = 7'd30;
        for (int i = 0; i < 4; i++) begin
            pulse(18'h200 + 18'(i), s, d);
            chk("hold_suppress", s, 1'b0);
        end
        chk("hold_not_taken", cic_rate, 7'd40);
        drive(1'b1, 1'b1, 18'h0);
        tick();
        chk("hold_locked", locked, 1'b1);
        chk("hold_ready_now", cfg_ready, 1'b1);
        drive(1'b0, 1'b0, 18'h0);
        tick();
        cfg_valid = 1'b0;
        chk("hold_accept_rate", cic_rate, 7'd30);
        chk("hold_restart", cic_clear, 1'b1);
        chk("hold_relock", locked, 1'b0);

        // Move back to 40, then reset during FILL.
        tick();
        tick();
        fill_seq("r30");
        cfg_valid = 1'b1;
        cfg_rate  = 7'd40;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        pulse(18'h300, s, d);
        pulse(18'h301, s, d);
        chk("r40_fill_state", cic_clear, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rate", cic_rate, 7'd10);
        chk("mid_rst_clear", cic_clear, 1'b1);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_out", out_strobe, 1'b0);
        tick();
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 18'h0);
        chk("rel_clear0", cic_clear, 1'b1);
        tick();
        drive(1'b0, 1'b0, 18'h0);
        chk("rel_clear1", cic_clear, 1'b1);
        chk("rel_no_stray", out_strobe, 1'b0);
        tick();
        chk("rel_fill", cic_clear, 1'b0);
        chk("rel_rate", cic_rate, 7'd10);
        fill_seq("rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
